// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit/receive path.
package uart_tx_pkg;

  // Transmit FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam logic        IDLE_LEVEL         = 1'b1;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_baud_rate_generator.sv
// Baud tick generator: one-cycle tick every DIVISOR clocks, restartable.
module baud_rate_generator #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap   = (cnt == CNT_W'(DIVISOR - 1));
  assign o_tick = wrap;

  // Free-running divider, restarted so the first tick lands DIVISOR clocks after a clear
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (i_clear || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule : baud_rate_generator

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with level-request handshake and one-cycle done pulse.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx,
  output logic                 o_tx_done,
  output logic                 o_busy
);

  localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic [3:0]           tick_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 armed;
  logic                 tick;
  logic                 accept;
  logic                 bit_end;

  assign accept     = (state == IDLE) && i_tx_start && armed;
  assign bit_end    = tick && (tick_cnt == 4'(OVERSAMPLE - 1));
  assign shreg_next = shreg >> 1;

  baud_rate_generator #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (accept),
    .o_tick  (tick)
  );

  // Frame sequencer: state, shift register, bit timing, handshake and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      shreg     <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      armed     <= 1'b1;
      o_tx      <= IDLE_LEVEL;
      o_tx_done <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      // A request must be seen low before another frame may be accepted
      if (!i_tx_start) begin
        armed <= 1'b1;
      end
      if (state != IDLE && tick) begin
        tick_cnt <= bit_end ? 4'd0 : tick_cnt + 4'd1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            shreg    <= i_tx_data;
            armed    <= 1'b0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= ~IDLE_LEVEL;
            o_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            o_tx  <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              state <= STOP;
              o_tx  <= IDLE_LEVEL;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              shreg   <= shreg_next;
              o_tx    <= shreg_next[0];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_tx_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: DIVISOR=4, 64 clocks per bit.
module tb_uart_tx;

  localparam int unsigned BIT_CYC   = 64;
  localparam int unsigned FRAME_CYC = 10 * BIT_CYC;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_tx_start;
  logic [7:0] i_tx_data;
  logic       o_tx;
  logic       o_tx_done;
  logic       o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(
    .CLK_FREQ   (1_536_000),
    .BAUD_RATE  (24_000),
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tx_start (i_tx_start),
    .i_tx_data  (i_tx_data),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line levels, bit 0 = start bit
    int         hold;   // extra cycles i_tx_start stays high after done
    bit         chg;    // drive i_tx_data to 0xFF mid-frame
  } vec_t;

  vec_t vecs[7];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; sends one frame and checks every cycle of it plus the post-done handshake
  task automatic send_frame(input vec_t v);
    int bad[10];
    int side_bad;
    logic [2:0] st;
    foreach (bad[k]) bad[k] = 0;
    side_bad = 0;
    i_tx_data  = v.data;
    i_tx_start = 1'b1;
    @(posedge i_clk);
    for (int n = 0; n < int'(FRAME_CYC); n++) begin
      @(negedge i_clk);
      if (n == 0) check(o_busy === 1'b1 && o_tx === 1'b0, "accept", {o_busy, o_tx}, 2'b10);
      if (v.chg && n == 200) i_tx_data = 8'hFF;
      if (o_tx !== v.line[n / BIT_CYC]) bad[n / BIT_CYC]++;
      if (o_busy !== 1'b1 || o_tx_done !== 1'b0) side_bad++;
      @(posedge i_clk);
    end
    foreach (bad[k]) check(bad[k] == 0, $sformatf("data 0x%0h line bit %0d bad cycles", v.data, k), bad[k], 0);
    check(side_bad == 0, "busy/done during frame bad cycles", side_bad, 0);
    @(negedge i_clk);
    st = {o_tx_done, o_busy, o_tx};
    check(st === 3'b101, "done pulse {done,busy,tx}", st, 3'b101);
    side_bad = 0;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if ({o_tx_done, o_busy, o_tx} !== 3'b001) side_bad++;
    end
    if (v.hold > 0) check(side_bad == 0, "held start retransmit bad cycles", side_bad, 0);
    i_tx_start = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    st = {o_tx_done, o_busy, o_tx};
    check(st === 3'b001, "post-done idle {done,busy,tx}", st, 3'b001);
  endtask

  initial begin
    logic [2:0] st;
    int bad;

    vecs[0] = '{data: 8'h1B, line: 10'h236, hold: 0,  chg: 1'b0};
    vecs[1] = '{data: 8'hA5, line: 10'h34A, hold: 20, chg: 1'b0};
    vecs[2] = '{data: 8'h1B, line: 10'h236, hold: 0,  chg: 1'b0};
    vecs[3] = '{data: 8'hA5, line: 10'h34A, hold: 0,  chg: 1'b0};
    vecs[4] = '{data: 8'hE9, line: 10'h3D2, hold: 0,  chg: 1'b0};
    vecs[5] = '{data: 8'h3F, line: 10'h27E, hold: 0,  chg: 1'b0};
    vecs[6] = '{data: 8'h00, line: 10'h200, hold: 0,  chg: 1'b1};

    i_reset    = 1'b0;
    i_tx_start = 1'b0;
    i_tx_data  = 8'h00;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    st = {o_tx_done, o_busy, o_tx};
    check(st === 3'b001, "reset state {done,busy,tx}", st, 3'b001);
    i_reset = 1'b1;

    // Idle with no request
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if ({o_tx_done, o_busy, o_tx} !== 3'b001) bad++;
    end
    check(bad == 0, "idle line bad cycles", bad, 0);

    // Table frames, back-to-back with the debug-style handshake
    foreach (vecs[i]) send_frame(vecs[i]);

    // Reset in the middle of a frame (cycle 300 falls in data bit 3 = 0 for 0xC3)
    i_tx_data  = 8'hC3;
    i_tx_start = 1'b1;
    @(posedge i_clk);
    repeat (300) @(posedge i_clk);
    @(negedge i_clk);
    check(o_tx === 1'b0 && o_busy === 1'b1, "pre-reset mid-frame {busy,tx}", {o_busy, o_tx}, 2'b10);
    i_reset    = 1'b0;
    i_tx_start = 1'b0;
    #1;
    st = {o_tx_done, o_busy, o_tx};
    check(st === 3'b001, "async reset mid-frame {done,busy,tx}", st, 3'b001);
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    bad = 0;
    for (int i = 0; i < int'(FRAME_CYC); i++) begin
      @(negedge i_clk);
      if ({o_tx_done, o_busy, o_tx} !== 3'b001) bad++;
    end
    check(bad == 0, "no resume after reset bad cycles", bad, 0);
    send_frame('{data: 8'h55, line: 10'h2AA, hold: 0, chg: 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx
